// File: rtl/preg_free_list.sv
// Physical-register free pool for a dual-issue rename stage: a circular FIFO
// of free tags with two allocation ports, two release ports and a refill sequence.
module preg_free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  parameter int DEPTH     = NUM_PREGS - NUM_AREGS,
  parameter int TAG_W     = $clog2(NUM_PREGS),
  parameter int PTR_W     = $clog2(DEPTH),
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_req_1,
  input  logic             alloc_req_2,
  output logic             alloc_gnt,
  output logic [TAG_W-1:0] alloc_tag_1,
  output logic [TAG_W-1:0] alloc_tag_2,
  input  logic             free_vld_1,
  input  logic             free_vld_2,
  input  logic [TAG_W-1:0] free_tag_1,
  input  logic [TAG_W-1:0] free_tag_2,
  output logic             ready,
  output logic             stall,
  output logic [CNT_W-1:0] free_count,
  output logic             err_overflow
);

  localparam int WIDE_W = CNT_W + 1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       r_state;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_err;
  logic [TAG_W-1:0] r_mem [DEPTH];

  logic              w_init;
  logic              w_run;
  logic [1:0]        w_nreq;
  logic              w_gnt;
  logic [1:0]        w_pops;
  logic [WIDE_W-1:0] w_base;
  logic              w_rel1;
  logic              w_rel2;
  logic              w_push1;
  logic              w_push2;
  logic [WIDE_W-1:0] w_after1;
  logic [WIDE_W-1:0] w_count_wide;
  logic              w_drop;
  logic [PTR_W-1:0]  w_head2;
  logic              w_we1;
  logic              w_we2;
  logic [PTR_W-1:0]  w_waddr1;
  logic [PTR_W-1:0]  w_waddr2;
  logic [TAG_W-1:0]  w_wdata1;
  logic [TAG_W-1:0]  w_wdata2;
  logic [0:0]        w_state_next;
  logic [PTR_W-1:0]  w_head_next;
  logic [PTR_W-1:0]  w_tail_next;
  logic [CNT_W-1:0]  w_count_next;

  assign w_init = (r_state == ST_INIT);
  assign w_run  = (r_state == ST_RUN);

  // Grant decision uses only the registered count; same-cycle frees never bypass.
  assign w_nreq = {1'b0, alloc_req_1} + {1'b0, alloc_req_2};
  assign w_gnt  = w_run && (w_nreq != 2'd0) &&
                  (WIDE_W'(w_nreq) <= WIDE_W'(r_count));
  assign w_pops = w_gnt ? w_nreq : 2'd0;

  // Releases are checked against the post-pop occupancy, slot 1 before slot 2.
  assign w_base       = WIDE_W'(r_count) - WIDE_W'(w_pops);
  assign w_rel1       = free_vld_1 && (free_tag_1 != '0);
  assign w_rel2       = free_vld_2 && (free_tag_2 != '0);
  assign w_push1      = w_run && w_rel1 && (w_base < WIDE_W'(DEPTH));
  assign w_after1     = w_base + WIDE_W'(w_push1);
  assign w_push2      = w_run && w_rel2 && (w_after1 < WIDE_W'(DEPTH));
  assign w_count_wide = w_after1 + WIDE_W'(w_push2);
  assign w_drop       = (w_rel1 && !w_push1) || (w_rel2 && !w_push2);

  assign w_head2 = r_head + PTR_W'(alloc_req_1);

  // During refill port 1 writes the initial tag sequence at the tail.
  assign w_we1    = w_init || w_push1;
  assign w_we2    = w_push2;
  assign w_waddr1 = r_tail;
  assign w_waddr2 = r_tail + PTR_W'(w_push1);
  assign w_wdata1 = w_init ? (TAG_W'(NUM_AREGS) + TAG_W'(r_tail)) : free_tag_1;
  assign w_wdata2 = free_tag_2;

  assign w_state_next = (w_init && (r_tail == PTR_W'(DEPTH - 1))) ? ST_RUN : r_state;
  assign w_head_next  = r_head + PTR_W'(w_pops);
  assign w_tail_next  = w_init ? (r_tail + PTR_W'(1))
                               : (r_tail + PTR_W'(w_push1) + PTR_W'(w_push2));
  assign w_count_next = w_init ? (r_count + CNT_W'(1)) : w_count_wide[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_head  <= w_head_next;
      r_tail  <= w_tail_next;
      r_count <= w_count_next;
      r_err   <= r_err | w_drop;
    end
  end

  // Pool storage carries no reset; refill rewrites every entry.
  always_ff @(posedge clk) begin
    if (w_we1) r_mem[w_waddr1] <= w_wdata1;
    if (w_we2) r_mem[w_waddr2] <= w_wdata2;
  end

  assign alloc_gnt    = w_gnt;
  assign alloc_tag_1  = r_mem[r_head];
  assign alloc_tag_2  = r_mem[w_head2];
  assign ready        = w_run;
  assign stall        = w_run && (alloc_req_1 || alloc_req_2) && !w_gnt;
  assign free_count   = r_count;
  assign err_overflow = r_err;

endmodule

// File: tb/tb_preg_free_list.sv
// Directed bench for preg_free_list: refill, drain, partial grant, empty-pool
// release, full-pool release with overflow, and mid-run reset.
module tb_preg_free_list;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alloc_req_1, alloc_req_2;
  logic       alloc_gnt;
  logic [5:0] alloc_tag_1, alloc_tag_2;
  logic       free_vld_1, free_vld_2;
  logic [5:0] free_tag_1, free_tag_2;
  logic       ready, stall;
  logic [5:0] free_count;
  logic       err_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  preg_free_list dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_req_1  (alloc_req_1),
    .alloc_req_2  (alloc_req_2),
    .alloc_gnt    (alloc_gnt),
    .alloc_tag_1  (alloc_tag_1),
    .alloc_tag_2  (alloc_tag_2),
    .free_vld_1   (free_vld_1),
    .free_vld_2   (free_vld_2),
    .free_tag_1   (free_tag_1),
    .free_tag_2   (free_tag_2),
    .ready        (ready),
    .stall        (stall),
    .free_count   (free_count),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, failures=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic set_in(input logic r1, input logic r2,
                        input logic v1, input logic [5:0] t1,
                        input logic v2, input logic [5:0] t2);
    alloc_req_1 = r1;
    alloc_req_2 = r2;
    free_vld_1  = v1;
    free_tag_1  = t1;
    free_vld_2  = v2;
    free_tag_2  = t2;
  endtask

  // Advance one edge and leave 1ns settling time before new inputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    repeat (3) tick();
    n_checks++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0b want 0", ready); end
    n_checks++;
    if (alloc_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %0b want 0", alloc_gnt); end
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", stall); end
    n_checks++;
    if (free_count !== 6'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", free_count); end
    n_checks++;
    if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b want 0", err_overflow); end
    $display("reset: ready=%0b gnt=%0b stall=%0b count=%0d err=%0b", ready, alloc_gnt, stall, free_count, err_overflow);
  endtask

  // Release reset between edges, then expect ready exactly on the 32nd edge.
  task automatic test_init(input string tag);
    set_in(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      n_checks++;
      if (ready !== (k == 32)) begin
        n_fail++;
        $display("FAIL %s_ready_edge%0d: got %0b want %0b", tag, k, ready, (k == 32));
      end
    end
    n_checks++;
    if (free_count !== 6'd32) begin n_fail++; $display("FAIL %s_count: got %0d want 32", tag, free_count); end
    n_checks++;
    if (alloc_tag_1 !== 6'd32) begin n_fail++; $display("FAIL %s_tag1: got %0d want 32", tag, alloc_tag_1); end
    $display("%s: ready=%0b count=%0d tag1=%0d", tag, ready, free_count, alloc_tag_1);
  endtask

  task automatic test_drain(input string tag);
    for (int i = 0; i < 16; i++) begin
      set_in(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
      #1;
      n_checks++;
      if (alloc_gnt !== 1'b1 || stall !== 1'b0 ||
          alloc_tag_1 !== 6'(32 + 2 * i) || alloc_tag_2 !== 6'(33 + 2 * i)) begin
        n_fail++;
        $display("FAIL %s_pair%0d: got gnt=%0b stall=%0b tags=(%0d,%0d) want gnt=1 stall=0 tags=(%0d,%0d)",
                 tag, i, alloc_gnt, stall, alloc_tag_1, alloc_tag_2, 32 + 2 * i, 33 + 2 * i);
      end
      $display("%s pair%0d: gnt=%0b tags=(%0d,%0d)", tag, i, alloc_gnt, alloc_tag_1, alloc_tag_2);
      tick();
    end
    #1;
    n_checks++;
    if (free_count !== 6'd0 || alloc_gnt !== 1'b0 || stall !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_empty: got count=%0d gnt=%0b stall=%0b want count=0 gnt=0 stall=1",
               tag, free_count, alloc_gnt, stall);
    end
    $display("%s empty: count=%0d gnt=%0b stall=%0b", tag, free_count, alloc_gnt, stall);
  endtask

  task automatic test_empty_free();
    set_in(1'b1, 1'b1, 1'b1, 6'd40, 1'b1, 6'd41);
    #1;
    n_checks++;
    if (alloc_gnt !== 1'b0 || stall !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_free_same_cycle: got gnt=%0b stall=%0b want gnt=0 stall=1", alloc_gnt, stall);
    end
    tick();
    set_in(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    #1;
    n_checks++;
    if (alloc_gnt !== 1'b1 || alloc_tag_1 !== 6'd40 || alloc_tag_2 !== 6'd41) begin
      n_fail++;
      $display("FAIL empty_free_next: got gnt=%0b tags=(%0d,%0d) want gnt=1 tags=(40,41)",
               alloc_gnt, alloc_tag_1, alloc_tag_2);
    end
    $display("empty_free: gnt=%0b tags=(%0d,%0d)", alloc_gnt, alloc_tag_1, alloc_tag_2);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    #1;
    n_checks++;
    if (free_count !== 6'd0) begin n_fail++; $display("FAIL empty_free_count: got %0d want 0", free_count); end
  endtask

  task automatic test_partial();
    set_in(1'b0, 1'b0, 1'b1, 6'd50, 1'b0, 6'd0);
    tick();
    set_in(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    #1;
    n_checks++;
    if (free_count !== 6'd1 || alloc_gnt !== 1'b0 || stall !== 1'b1 || alloc_tag_1 !== 6'd50) begin
      n_fail++;
      $display("FAIL partial_both: got count=%0d gnt=%0b stall=%0b tag1=%0d want count=1 gnt=0 stall=1 tag1=50",
               free_count, alloc_gnt, stall, alloc_tag_1);
    end
    tick();
    set_in(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    #1;
    n_checks++;
    if (free_count !== 6'd1 || alloc_gnt !== 1'b1 || alloc_tag_2 !== 6'd50 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL partial_slot2: got count=%0d gnt=%0b tag2=%0d stall=%0b want count=1 gnt=1 tag2=50 stall=0",
               free_count, alloc_gnt, alloc_tag_2, stall);
    end
    $display("partial: slot2 gnt=%0b tag2=%0d", alloc_gnt, alloc_tag_2);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    #1;
    n_checks++;
    if (free_count !== 6'd0) begin n_fail++; $display("FAIL partial_count: got %0d want 0", free_count); end
  endtask

  task automatic test_full_overflow();
    for (int k = 0; k < 16; k++) begin
      set_in(1'b0, 1'b0, 1'b1, 6'(20 + 2 * k), 1'b1, 6'(21 + 2 * k));
      tick();
    end
    set_in(1'b1, 1'b1, 1'b1, 6'd60, 1'b1, 6'd61);
    #1;
    n_checks++;
    if (free_count !== 6'd32 || err_overflow !== 1'b0 || alloc_gnt !== 1'b1 ||
        alloc_tag_1 !== 6'd20 || alloc_tag_2 !== 6'd21) begin
      n_fail++;
      $display("FAIL full_swap: got count=%0d err=%0b gnt=%0b tags=(%0d,%0d) want count=32 err=0 gnt=1 tags=(20,21)",
               free_count, err_overflow, alloc_gnt, alloc_tag_1, alloc_tag_2);
    end
    tick();
    set_in(1'b0, 1'b0, 1'b1, 6'd45, 1'b1, 6'd0);
    #1;
    n_checks++;
    if (free_count !== 6'd32 || err_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL full_swap_after: got count=%0d err=%0b want count=32 err=0", free_count, err_overflow);
    end
    tick();
    set_in(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    #1;
    n_checks++;
    if (free_count !== 6'd32 || err_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_drop: got count=%0d err=%0b want count=32 err=1", free_count, err_overflow);
    end
    repeat (4) tick();
    n_checks++;
    if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky: got %0b want 1", err_overflow); end
    set_in(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    #1;
    n_checks++;
    if (alloc_tag_1 !== 6'd22 || alloc_tag_2 !== 6'd23) begin
      n_fail++;
      $display("FAIL full_order: got tags=(%0d,%0d) want (22,23)", alloc_tag_1, alloc_tag_2);
    end
    $display("overflow: count=%0d err=%0b next=(%0d,%0d)", free_count, err_overflow, alloc_tag_1, alloc_tag_2);
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 12; k++) begin
      set_in(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
      tick();
    end
    set_in(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    tick();
    set_in(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
    #1;
    n_checks++;
    if (free_count !== 6'd7 || alloc_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: got count=%0d gnt=%0b want count=7 gnt=1", free_count, alloc_gnt);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ready !== 1'b0 || alloc_gnt !== 1'b0 || stall !== 1'b0 ||
        free_count !== 6'd0 || err_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got ready=%0b gnt=%0b stall=%0b count=%0d err=%0b want all 0",
               ready, alloc_gnt, stall, free_count, err_overflow);
    end
    $display("mid_reset: ready=%0b gnt=%0b stall=%0b count=%0d err=%0b",
             ready, alloc_gnt, stall, free_count, err_overflow);
    tick();
    test_init("reinit");
    test_drain("redrain");
  endtask

  initial begin
    test_reset();
    test_init("init");
    test_drain("drain");
    test_empty_free();
    test_partial();
    test_full_overflow();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/preg_free_list.md
# preg_free_list

Controller for the physical-register free pool used by the dual-issue rename stage. It holds unallocated physical register tags in a circular FIFO and hands out up to two tags per cycle to rename (`rd_1`, `rd_2`). It accepts up to two released tags per cycle from retire. It also produces the stall and grant handshake that rename uses to decide whether a pair of instructions may proceed. The block replaces the per-cycle linear scan of a free bitmap with a pointer-based allocator that has a defined initialisation sequence.

## Interface
- `NUM_PREGS`, 64, total physical registers; tags are `$clog2(NUM_PREGS)` = 6 bits.
- `NUM_AREGS`, 32, architectural registers; p0..p(NUM_AREGS-1) are mapped at reset and never in the initial pool.
- `DEPTH`, NUM_PREGS-NUM_AREGS = 32, FIFO entries; pointers are `$clog2(DEPTH)` = 5 bits.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `alloc_req_1` in 1: rename slot 1 needs a destination tag (`rd_1 != 0`).
- `alloc_req_2` in 1: rename slot 2 needs a destination tag (`rd_2 != 0`).
- `alloc_gnt` out 1: all requested tags are granted this cycle; the grant is all-or-nothing.
- `alloc_tag_1` out 6: tag for slot 1; valid when `alloc_gnt && alloc_req_1`.
- `alloc_tag_2` out 6: tag for slot 2; valid when `alloc_gnt && alloc_req_2`.
- `free_vld_1`, `free_vld_2` in 1 each: retire releases a tag.
- `free_tag_1`, `free_tag_2` in 6 each: the released tags.
- `ready` out 1: initialisation is complete.
- `stall` out 1: `ready && (alloc_req_1||alloc_req_2) && !alloc_gnt`.
- `free_count` out 6: number of valid FIFO entries, range 0..DEPTH.
- `err_overflow` out 1: sticky; set when a release is dropped.

## Operation
- State machine with two states, INIT and RUN. Reset enters INIT.
- INIT:
  - Each cycle, write tag `NUM_AREGS+i` at `mem[i]`, where `i` is the tail; tail and count each increment by 1.
  - After DEPTH writes (entry 31 = tag 63), go to RUN. Tail has wrapped to 0 and count = 32.
  - `ready`=0 and `alloc_gnt`=0 throughout.
  - Frees presented during INIT are dropped and set `err_overflow`.
- RUN:
  - Requested count is `nreq = alloc_req_1 + alloc_req_2`.
  - `alloc_gnt = (nreq != 0) && (nreq <= free_count)`.
  - Only the registered count is used. A tag freed in the same cycle is never bypassed to an allocation.
  - Tag selection: `alloc_tag_1 = mem[head]`. `alloc_tag_2 = mem[head + alloc_req_1]`, so slot 2 alone takes `mem[head]`.
  - On grant, head advances by `nreq`, mod DEPTH.
- Releases are pushed at the tail in order: slot 1 first, then slot 2.
  - A release with tag 0 is ignored silently; p0 is hardwired and is never freed.
  - A release that would make the count exceed DEPTH is dropped and sets `err_overflow`. The other slot is still accepted if it fits.
- Count update each cycle: `count_next = count + pushes - pops`. Compute at 7 bits internally and saturate-check before truncating.
- Simultaneous allocation and release in the same cycle:
  - Both take effect.
  - When count = 0 and 2 frees arrive, the grant is 0 this cycle and 2 tags are available next cycle.
  - When count = DEPTH, a grant of 2 plus 2 frees is legal. Overflow is checked against `count - pops`.
- Pointers wrap modulo DEPTH with no special casing.
- `err_overflow` clears only on reset.

## Timing
- Reset values: `ready`=0, `alloc_gnt`=0, `stall`=0, `free_count`=0, `err_overflow`=0, head=tail=0, state INIT.
  - `alloc_tag_*` output `mem[0]`; the value is don't-care until `ready`.
- `ready` rises at the 32nd rising edge after `rst_n` deasserts and stays high until the next reset.
- `alloc_gnt`, `alloc_tag_*` and `stall` are combinational from the registered state and the request inputs, with zero-cycle latency. Rename samples them in the same cycle.
- Head, tail, count and mem update on the rising edge.
  - A tag freed in cycle N is allocatable no earlier than cycle N+1.
  - A tag granted in cycle N is not re-presented unless it is freed again.
- Asserting `rst_n` low mid-operation immediately forces every output to its reset value and restarts INIT. Pool contents are rebuilt from scratch.

## Test plan
- Reset release, then 32 cycles of no stimulus: `ready` rises after exactly 32 edges, `free_count`=32, and `alloc_tag_1`=32.
- Both requests held for 16 cycles: pairs (32,33), (34,35) … (62,63) are granted. Next cycle `free_count`=0, `alloc_gnt`=0 and `stall`=1.
- With count=1, assert both requests: grant is 0 and head is unchanged. Drop `alloc_req_1`: slot 2 is granted the remaining tag.
- With count=0, free tags 40 and 41 together with both requests: no grant that cycle. Next cycle the grant is 1 and the tags are (40,41).
- With count=32, free 45 and tag 0 with no allocation: tag 0 is ignored, tag 45 is dropped, `err_overflow`=1 and it stays sticky.
- Pull `rst_n` low mid-run with count=7: outputs go to reset values immediately and the INIT refill produces tags 32..63 again.
